// File: rtl/afu_csr_pkg.sv
// afu_csr_pkg: CCI-P MMIO types, CSR offsets, DFH fields, CTRL bit positions and the partial-write merge helper
package afu_csr_pkg;
  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic [8:0]  tid;
  } t_ccip_c0_ReqMmioHdr;
  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    logic [63:0]         data;
    logic                mmioRdValid;
    logic                mmioWrValid;
  } t_if_ccip_c0_Rx;
  typedef struct packed {
    t_if_ccip_c0_Rx c0;
  } t_if_ccip_Rx;
  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;
  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;
  localparam logic [17:0] OFF_DFH      = 18'h00;
  localparam logic [17:0] OFF_AFU_ID_L = 18'h08;
  localparam logic [17:0] OFF_AFU_ID_H = 18'h10;
  localparam logic [17:0] OFF_SCRATCH  = 18'h28;
  localparam logic [17:0] OFF_CTRL     = 18'h30;
  localparam logic [17:0] OFF_BUF_ADDR = 18'h38;
  localparam logic [17:0] OFF_STATUS   = 18'h40;
  localparam logic [3:0]  DFH_TYPE_AFU = 4'h1;
  localparam logic        DFH_EOL      = 1'b1;
  localparam logic [23:0] DFH_NEXT     = 24'h0;
  localparam logic [3:0]  DFH_REV      = 4'h0;
  localparam logic [11:0] DFH_ID       = 12'h0;
  localparam logic [63:0] DFH_VAL      = {DFH_TYPE_AFU, 19'b0, DFH_EOL, DFH_NEXT, DFH_REV, DFH_ID};
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_CLR_DONE_BIT = 1;
  function automatic logic [63:0] merge_wr(input logic [63:0] cur, input logic [63:0] wdata, input logic len8, input logic hi);
    return len8 ? wdata : hi ? {wdata[31:0], cur[31:0]} : {cur[63:32], wdata[31:0]};
  endfunction
endpackage

// File: rtl/afu_mmio_csr.sv
// afu_mmio_csr: CCI-P MMIO CSR block (DFH, AFU_ID, CTRL, BUF_ADDR, STATUS; SCRATCH at 0x28 under MMIO_SCRATCH_EN) with 2-stage read pipeline; ports clk, rst, rx, c2_tx, start, buf_addr, done_in, busy_in
module afu_mmio_csr
  import afu_csr_pkg::*;
#(
  parameter logic [63:0] AFU_ID_L = 64'h0,
  parameter logic [63:0] AFU_ID_H = 64'h0
) (
  input  logic           clk,
  input  logic           rst,
  input  t_if_ccip_Rx    rx,
  output t_if_ccip_c2_Tx c2_tx,
  output logic           start,
  output logic [63:0]    buf_addr,
  input  logic           done_in,
  input  logic           busy_in
);
  logic [17:0] req_off;
  logic        wr_len8;
  logic        ctrl_wr;
  logic        buf_wr;
  logic        done_sticky;
  logic        s1_valid;
  logic [8:0]  s1_tid;
  logic [17:0] s1_off;
  logic [63:0] scratch;
  logic [63:0] rd_data;
  assign req_off = {rx.c0.hdr.address[15:1], 3'b000};
  assign wr_len8 = rx.c0.hdr.length == 2'd1;
  assign ctrl_wr = rx.c0.mmioWrValid && req_off == OFF_CTRL;
  assign buf_wr  = rx.c0.mmioWrValid && req_off == OFF_BUF_ADDR;
`ifdef MMIO_SCRATCH_EN
  logic scr_wr;
  assign scr_wr = rx.c0.mmioWrValid && req_off == OFF_SCRATCH;
  always_ff @(posedge clk)
    if (rst) scratch <= '0;
    else if (scr_wr) scratch <= merge_wr(scratch, rx.c0.data, wr_len8, rx.c0.hdr.address[0]);
`else
  assign scratch = '0;
`endif
  assign rd_data = s1_off == OFF_DFH      ? DFH_VAL :
                   s1_off == OFF_AFU_ID_L ? AFU_ID_L :
                   s1_off == OFF_AFU_ID_H ? AFU_ID_H :
                   s1_off == OFF_SCRATCH  ? scratch :
                   s1_off == OFF_BUF_ADDR ? buf_addr :
                   s1_off == OFF_STATUS   ? {62'b0, done_sticky, busy_in} : 64'h0;
  always_ff @(posedge clk)
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_tid      <= '0;
      s1_off      <= '0;
      c2_tx       <= '0;
      start       <= 1'b0;
      buf_addr    <= '0;
      done_sticky <= 1'b0;
    end else begin
      s1_valid          <= rx.c0.mmioRdValid;
      s1_tid            <= rx.c0.hdr.tid;
      s1_off            <= req_off;
      c2_tx.mmioRdValid <= s1_valid;
      c2_tx.hdr.tid     <= s1_tid;
      c2_tx.data        <= rd_data;
      start             <= ctrl_wr && rx.c0.data[CTRL_START_BIT];
      if (buf_wr) buf_addr <= merge_wr(buf_addr, rx.c0.data, wr_len8, rx.c0.hdr.address[0]);
      done_sticky       <= done_in || (done_sticky && !(ctrl_wr && rx.c0.data[CTRL_CLR_DONE_BIT]));
    end
endmodule

// File: tb/tb_afu_mmio_csr.sv
// tb_afu_mmio_csr: randomized scoreboard bench for afu_mmio_csr against a register-map reference model
module tb_afu_mmio_csr;
  import afu_csr_pkg::*;
  localparam logic [63:0] ID_L = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] ID_H = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] DFH_EXP = 64'h1000_0100_0000_0000;
  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
    int          due;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start;
  logic done_in = 1'b0;
  logic busy_in = 1'b0;
  logic [63:0] buf_addr;
  t_if_ccip_Rx rx = '0;
  t_if_ccip_c2_Tx c2_tx;
  exp_t q[$];
  exp_t e;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  logic [63:0] m_buf = '0, m_scr = '0, p_buf = '0;
  bit m_done = 0, drv_start = 0, p_start = 0, p_rst = 1;
  afu_mmio_csr #(.AFU_ID_L(ID_L), .AFU_ID_H(ID_H)) dut (
    .clk(clk), .rst(rst), .rx(rx), .c2_tx(c2_tx), .start(start),
    .buf_addr(buf_addr), .done_in(done_in), .busy_in(busy_in)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [63:0] half_write(input logic [63:0] cur, input logic a0, input logic [1:0] len, input logic [63:0] d);
    if (len == 2'd1) return d;
    if (a0) return {d[31:0], cur[31:0]};
    return {cur[63:32], d[31:0]};
  endfunction
  function automatic logic [63:0] model_read(input logic [15:0] a);
    case (int'(a[15:1]))
      0: return DFH_EXP;
      1: return ID_L;
      2: return ID_H;
`ifdef MMIO_SCRATCH_EN
      5: return m_scr;
`endif
      7: return m_buf;
      8: return {62'b0, m_done, busy_in};
      default: return 64'h0;
    endcase
  endfunction
  task automatic model_write(input logic [15:0] a, input logic [1:0] len, input logic [63:0] d);
    case (int'(a[15:1]))
      5: m_scr = half_write(m_scr, a[0], len, d);
      6: begin
        if (d[0]) drv_start = 1;
        if (d[1]) m_done = 0;
      end
      7: m_buf = half_write(m_buf, a[0], len, d);
      default: ;
    endcase
  endtask
  task automatic op(input bit rd, input bit wr, input logic [15:0] a, input logic [1:0] len,
                    input logic [63:0] d, input logic [8:0] tid, input bit done);
    exp_t x;
    rx = '0;
    rx.c0.mmioRdValid = rd;
    rx.c0.mmioWrValid = wr;
    rx.c0.hdr.address = a;
    rx.c0.hdr.length = len;
    rx.c0.hdr.tid = tid;
    rx.c0.data = d;
    done_in = done;
    drv_start = 0;
    if (wr) model_write(a, len, d);
    if (done) m_done = 1;
    if (rd) begin
      x.tid = tid;
      x.data = model_read(a);
      x.due = cyc + 2;
      q.push_back(x);
    end
    @(posedge clk);
    #1;
    rx = '0;
    done_in = 0;
    drv_start = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) op(0, 0, 16'h0, 2'd0, 64'h0, 9'h0, 0);
  endtask
  task automatic do_reset();
    rst = 1;
    q.delete();
    m_buf = '0;
    m_scr = '0;
    m_done = 0;
    drv_start = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 0;
  endtask
  always @(negedge clk) begin
    check("start", {63'b0, start}, {63'b0, p_rst ? 1'b0 : p_start});
    check("buf_addr", buf_addr, p_rst ? 64'h0 : p_buf);
    if (p_rst) begin
      check("rst_c2_valid", {63'b0, c2_tx.mmioRdValid}, 64'h0);
      check("rst_c2_data", c2_tx.data, 64'h0);
      check("rst_c2_tid", {55'b0, c2_tx.hdr.tid}, 64'h0);
    end else if (c2_tx.mmioRdValid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got tid %h data %h, required no response", c2_tx.hdr.tid, c2_tx.data);
      end else begin
        e = q.pop_front();
        check("rsp_tid", {55'b0, c2_tx.hdr.tid}, {55'b0, e.tid});
        check("rsp_data", c2_tx.data, e.data);
        check("rsp_latency", 64'(cyc), 64'(e.due));
      end
    end else if (q.size() != 0 && q[0].due <= cyc) begin
      tests++;
      fails++;
      $display("FAIL missing_rsp: got no response, required tid %h in cycle %0d", q[0].tid, q[0].due);
      void'(q.pop_front());
    end
    p_rst = rst;
    p_start = drv_start;
    p_buf = m_buf;
  end
  initial begin
    int k;
    int qi;
    logic [15:0] a;
    logic [1:0] len;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    op(1, 0, 16'h0000, 2'd1, 64'h0, 9'h1A, 0);
    op(0, 1, 16'h000E, 2'd1, 64'hDEAD_BEEF_0123_4567, 9'h0, 0);
    op(0, 1, 16'h000F, 2'd0, 64'h0000_0000_AAAA_AAAA, 9'h0, 0);
    op(1, 0, 16'h000E, 2'd0, 64'h0, 9'h05, 0);
    op(0, 1, 16'h000E, 2'd0, 64'h0000_0000_5555_1111, 9'h0, 0);
    op(0, 1, 16'h000C, 2'd1, 64'h1, 9'h0, 0);
    idle(2);
    op(0, 1, 16'h000C, 2'd1, 64'h1, 9'h0, 0);
    op(0, 1, 16'h000C, 2'd1, 64'h1, 9'h0, 0);
    idle(1);
    op(0, 0, 16'h0, 2'd0, 64'h0, 9'h0, 1);
    op(1, 0, 16'h0010, 2'd1, 64'h0, 9'h06, 0);
    op(0, 1, 16'h000C, 2'd1, 64'h2, 9'h0, 0);
    op(1, 0, 16'h0010, 2'd1, 64'h0, 9'h07, 0);
    op(0, 1, 16'h000C, 2'd1, 64'h2, 9'h0, 1);
    op(1, 0, 16'h0010, 2'd1, 64'h0, 9'h08, 0);
    op(1, 0, 16'h0002, 2'd1, 64'h0, 9'h01, 0);
    op(1, 0, 16'h0004, 2'd1, 64'h0, 9'h02, 0);
    op(1, 0, 16'h0014, 2'd1, 64'h0, 9'h03, 0);
    op(1, 0, 16'h000E, 2'd1, 64'h0, 9'h04, 0);
    op(0, 1, 16'h0000, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 9'h0, 0);
    op(0, 1, 16'h0014, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 9'h0, 0);
    op(1, 0, 16'h0000, 2'd1, 64'h0, 9'h09, 0);
    idle(2);
    busy_in = 1;
    op(1, 0, 16'h0010, 2'd0, 64'h0, 9'h0A, 0);
    idle(2);
    busy_in = 0;
    op(1, 0, 16'h0002, 2'd1, 64'h0, 9'h0B, 0);
    do_reset();
    idle(3);
    op(0, 1, 16'h000A, 2'd1, 64'hC0FF_EE00_1234_5678, 9'h0, 0);
    op(1, 0, 16'h000A, 2'd1, 64'h0, 9'h0C, 0);
    op(0, 1, 16'h000B, 2'd0, 64'h0000_0000_9999_0000, 9'h0, 0);
    op(1, 0, 16'h000A, 2'd0, 64'h0, 9'h0D, 0);
    idle(2);
    for (int b = 0; b < 10; b++) begin
      busy_in = 1'($urandom_range(0, 1));
      for (int i = 0; i < 30; i++) begin
        k = $urandom_range(0, 9);
        qi = $urandom_range(0, 10);
        len = 2'($urandom_range(0, 1));
        a = 16'(qi * 2);
        if ((qi == 5 || qi == 7) && len == 2'd0) a[0] = 1'($urandom_range(0, 1));
        if (k < 4) op(1, 0, a, len, 64'h0, 9'($urandom), $urandom_range(0, 7) == 0);
        else if (k < 7) op(0, 1, a, len, {$urandom, $urandom}, 9'h0, $urandom_range(0, 7) == 0);
        else if (k < 9) op(0, 1, 16'h000C, 2'd1, 64'($urandom_range(0, 3)), 9'h0, $urandom_range(0, 3) == 0);
        else op(0, 0, 16'h0, 2'd0, 64'h0, 9'h0, 1);
      end
      idle(2);
    end
    for (int t = 0; t < 10 && q.size() != 0; t++) idle(1);
    check("drain_empty", 64'(q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
